// File: rtl/vector_memory_responder.sv
// Vector memory responder: 64-bit word array with a zero-fill phase after reset and a fixed-latency response pipe.
// Optional VECTOR_MEM_BOUNDS_CHECK_EN adds out-of-range detection and the sticky bounds_err output.
`timescale 1ns/1ps

package vector_memory_pkg;
    typedef enum logic {
        READ_REQ  = 1'b0,
        WRITE_REQ = 1'b1
    } access_type_e;

    typedef struct packed {
        logic         vld;
        access_type_e access_type;
        logic [7:0]   access_id;
        logic [3:0]   core_id;
        logic [63:0]  addr;
        logic [7:0]   byte_en;
        logic [63:0]  data;
    } request_t;
endpackage

module vector_memory_responder
    import vector_memory_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int RD_LAT    = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  request_t mem_req,
    output logic     req_grant,
    output request_t mem_rsp,
`ifdef VECTOR_MEM_BOUNDS_CHECK_EN
    output logic     bounds_err,
`endif
    output logic     init_done
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   clr_cnt_q;
    logic [63:0]     mem_q [MEM_DEPTH];
    request_t        rsp_q [RD_LAT];
    request_t        rsp_d;

    logic [AW-1:0]   idx;
    logic            accept;
    logic            oob;
    logic            wr_en;

    assign req_grant = (state_q == READY);
    assign init_done = (state_q == READY);
    assign accept    = mem_req.vld && req_grant;
    assign idx       = mem_req.addr[3 +: AW];

`ifdef VECTOR_MEM_BOUNDS_CHECK_EN
    logic bounds_err_q;

    assign oob        = |mem_req.addr[63:3+AW];
    assign bounds_err = bounds_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bounds_err_q <= 1'b0;
        else if (accept && oob)
            bounds_err_q <= 1'b1;
    end
`else
    assign oob = 1'b0;
`endif

    assign wr_en = accept && (mem_req.access_type == WRITE_REQ) && !oob;

    // Clear walks one word per cycle; READY is reached after exactly MEM_DEPTH edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == AW'(MEM_DEPTH - 1))
                        state_q <= READY;
                end
                default: state_q <= READY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 8; b++)
                if (mem_req.byte_en[b])
                    mem_q[idx][8*b +: 8] <= mem_req.data[8*b +: 8];
        end
    end

    // Read sampled before this edge's write lands, so it sees only earlier writes.
    always_comb begin
        rsp_d = '0;
        if (accept) begin
            rsp_d     = mem_req;
            rsp_d.vld = 1'b1;
            if (mem_req.access_type == READ_REQ)
                rsp_d.data = oob ? 64'hDEAD_BEEF_DEAD_BEEF : mem_q[idx];
            else
                rsp_d.data = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++)
                rsp_q[i] <= '0;
        end else begin
            rsp_q[0] <= rsp_d;
            for (int i = 1; i < RD_LAT; i++)
                rsp_q[i] <= rsp_q[i-1];
        end
    end

    assign mem_rsp = rsp_q[RD_LAT-1];

endmodule

// File: tb/tb_vector_memory_responder.sv
// Directed self-checking bench for vector_memory_responder (default MEM_DEPTH=1024, RD_LAT=2).
`timescale 1ns/1ps

module tb_vector_memory_responder;
    import vector_memory_pkg::*;

    localparam int MEM_DEPTH = 1024;
    localparam int RD_LAT    = 2;

    logic     clk = 1'b0;
    logic     reset;
    request_t mem_req;
    request_t mem_rsp;
    logic     req_grant;
    logic     init_done;
`ifdef VECTOR_MEM_BOUNDS_CHECK_EN
    logic     bounds_err;
`endif

    int errors = 0;
    int checks = 0;

    vector_memory_responder #(.MEM_DEPTH(MEM_DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .req_grant (req_grant),
        .mem_rsp   (mem_rsp),
`ifdef VECTOR_MEM_BOUNDS_CHECK_EN
        .bounds_err(bounds_err),
`endif
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Release reset on a falling edge and count sampled cycles with grant low.
    // Optionally hold a request during the clear and tally any response pulses seen.
    task automatic release_and_count(input logic hold, output int n, output int stale);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n = 0;
        stale = 0;
        if (hold)
            mem_req = '{vld:1'b1, access_type:READ_REQ, access_id:8'h55, core_id:4'h1,
                        addr:64'h40, byte_en:8'h00, data:64'h0};
        while (req_grant !== 1'b1 && n < 2000) begin
            if (mem_rsp !== '0) stale++;
            n++;
            if (n == 1000) mem_req = '0;
            @(negedge clk);
            #1;
        end
        mem_req = '0;
    endtask

    // Issue one request and capture the response slot RD_LAT falling edges later.
    task automatic xact(input access_type_e t, input logic [7:0] id, input logic [63:0] addr,
                        input logic [7:0] be, input logic [63:0] d, output request_t rsp);
        @(negedge clk);
        mem_req = '{vld:1'b1, access_type:t, access_id:id, core_id:4'h2,
                    addr:addr, byte_en:be, data:d};
        for (int k = 1; k <= RD_LAT; k++) begin
            @(negedge clk);
            if (k == 1) mem_req = '0;
            if (k == RD_LAT) rsp = mem_rsp;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        mem_req = '0;
        #12;
        checks++;
        if (mem_rsp !== '0) begin errors++; $display("FAIL reset_rsp: got %h expected 0", mem_rsp); end
        checks++;
        if (req_grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0", req_grant); end
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
`ifdef VECTOR_MEM_BOUNDS_CHECK_EN
        checks++;
        if (bounds_err !== 1'b0) begin errors++; $display("FAIL reset_bounds_err: got %b expected 0", bounds_err); end
`endif
    endtask

    task automatic test_init();
        int n, stale;
        request_t r;
        release_and_count(1'b0, n, stale);
        checks++;
        if (n != MEM_DEPTH) begin errors++; $display("FAIL init_cycles: got %0d expected %0d", n, MEM_DEPTH); end
        checks++;
        if (init_done !== 1'b1 || req_grant !== 1'b1) begin
            errors++; $display("FAIL init_ready: got done=%b grant=%b expected 1/1", init_done, req_grant);
        end
        xact(READ_REQ, 8'd1, 64'h40, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, r);
        checks++;
        if (r.vld !== 1'b1 || r.data !== 64'h0 || r.access_id !== 8'd1) begin
            errors++; $display("FAIL init_read40: got vld=%b id=%h data=%h expected 1/01/0", r.vld, r.access_id, r.data);
        end
    endtask

    task automatic test_write_read();
        request_t r;
        @(negedge clk);
        mem_req = '{vld:1'b1, access_type:WRITE_REQ, access_id:8'd3, core_id:4'h7,
                    addr:64'h10, byte_en:8'hFF, data:64'h1122334455667788};
        for (int k = 1; k <= RD_LAT + 1; k++) begin
            @(negedge clk);
            r = mem_rsp;
            if (k == 1)
                mem_req = '{vld:1'b1, access_type:READ_REQ, access_id:8'd4, core_id:4'h7,
                            addr:64'h10, byte_en:8'h00, data:64'h0};
            if (k == 2) mem_req = '0;
            if (k == RD_LAT) begin
                checks++;
                if (r.vld !== 1'b1 || r.access_type !== WRITE_REQ || r.access_id !== 8'd3 ||
                    r.data !== 64'h0 || r.byte_en !== 8'hFF || r.addr !== 64'h10 || r.core_id !== 4'h7) begin
                    errors++; $display("FAIL wr_rsp: got %h expected write echo id 3 data 0", r);
                end
            end
            if (k == RD_LAT + 1) begin
                checks++;
                if (r.vld !== 1'b1 || r.access_type !== READ_REQ || r.access_id !== 8'd4 ||
                    r.data !== 64'h1122334455667788) begin
                    errors++; $display("FAIL rd_after_wr: got id=%h data=%h expected 04/1122334455667788", r.access_id, r.data);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (mem_rsp !== '0) begin errors++; $display("FAIL idle_rsp: got %h expected 0", mem_rsp); end
    endtask

    task automatic test_partial();
        request_t r;
        xact(WRITE_REQ, 8'd10, 64'h18, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, r);
        checks++;
        if (r.data !== 64'h0 || r.byte_en !== 8'h0F) begin
            errors++; $display("FAIL pw_rsp: got data=%h be=%h expected 0/0f", r.data, r.byte_en);
        end
        xact(READ_REQ, 8'd11, 64'h18, 8'h00, 64'h0, r);
        checks++;
        if (r.data !== 64'h00000000_BBBBBBBB) begin
            errors++; $display("FAIL pw_low: got %h expected 00000000bbbbbbbb", r.data);
        end
        xact(WRITE_REQ, 8'd12, 64'h18, 8'hF0, 64'hCCCCCCCC_DDDDDDDD, r);
        xact(READ_REQ, 8'd13, 64'h18, 8'hFF, 64'h0, r);
        checks++;
        if (r.data !== 64'hCCCCCCCC_BBBBBBBB) begin
            errors++; $display("FAIL pw_merge: got %h expected ccccccccbbbbbbbb", r.data);
        end
        xact(READ_REQ, 8'd14, 64'h15, 8'h00, 64'h0, r);
        checks++;
        if (r.data !== 64'h1122334455667788 || r.addr !== 64'h15) begin
            errors++; $display("FAIL low_addr_ignored: got addr=%h data=%h expected 15/1122334455667788", r.addr, r.data);
        end
    endtask

    task automatic test_bounds();
        request_t r;
        xact(WRITE_REQ, 8'd20, 64'h0, 8'hFF, 64'h0123456789ABCDEF, r);
`ifdef VECTOR_MEM_BOUNDS_CHECK_EN
        checks++;
        if (bounds_err !== 1'b0) begin errors++; $display("FAIL bounds_pre: got %b expected 0", bounds_err); end
`endif
        xact(READ_REQ, 8'd21, 64'h2000, 8'h00, 64'h0, r);
        checks++;
`ifdef VECTOR_MEM_BOUNDS_CHECK_EN
        if (r.vld !== 1'b1 || r.data !== 64'hDEADBEEFDEADBEEF) begin
            errors++; $display("FAIL oob_read: got vld=%b data=%h expected 1/deadbeefdeadbeef", r.vld, r.data);
        end
        checks++;
        if (bounds_err !== 1'b1) begin errors++; $display("FAIL bounds_set: got %b expected 1", bounds_err); end
`else
        if (r.vld !== 1'b1 || r.data !== 64'h0123456789ABCDEF) begin
            errors++; $display("FAIL wrap_read: got vld=%b data=%h expected 1/0123456789abcdef", r.vld, r.data);
        end
`endif
        xact(WRITE_REQ, 8'd22, 64'h2008, 8'hFF, 64'hFEDCBA9876543210, r);
        xact(READ_REQ, 8'd23, 64'h8, 8'h00, 64'h0, r);
        checks++;
`ifdef VECTOR_MEM_BOUNDS_CHECK_EN
        if (r.data !== 64'h0) begin errors++; $display("FAIL oob_write_dropped: got %h expected 0", r.data); end
        checks++;
        if (bounds_err !== 1'b1) begin errors++; $display("FAIL bounds_sticky: got %b expected 1", bounds_err); end
`else
        if (r.data !== 64'hFEDCBA9876543210) begin
            errors++; $display("FAIL wrap_write: got %h expected fedcba9876543210", r.data);
        end
`endif
    endtask

    task automatic test_back_to_back();
        request_t r;
        int bad = 0;
        int pulses = 0;
        for (int i = 0; i < 64 + RD_LAT; i++) begin
            @(negedge clk);
            r = mem_rsp;
            if (r.vld === 1'b1) pulses++;
            if (i >= RD_LAT) begin
                checks++;
                if (r.vld !== 1'b1 || r.access_id !== 8'(i - RD_LAT) || r.core_id !== 4'hA ||
                    r.data !== 64'h0 || r.access_type !== READ_REQ) begin
                    errors++; bad++;
                    if (bad < 5)
                        $display("FAIL burst_rsp[%0d]: got vld=%b id=%h core=%h data=%h expected 1/%h/a/0",
                                 i - RD_LAT, r.vld, r.access_id, r.core_id, r.data, 8'(i - RD_LAT));
                end
            end
            if (i < 64)
                mem_req = '{vld:1'b1, access_type:READ_REQ, access_id:8'(i), core_id:4'hA,
                            addr:64'h400 + 64'(8 * i), byte_en:8'h00, data:64'h0};
            else
                mem_req = '0;
        end
        @(negedge clk);
        if (mem_rsp.vld === 1'b1) pulses++;
        checks++;
        if (pulses != 64) begin errors++; $display("FAIL burst_count: got %0d expected 64", pulses); end
    endtask

    task automatic test_reset_inflight();
        request_t r;
        int n, stale, rst_bad;
        @(negedge clk);
        mem_req = '{vld:1'b1, access_type:READ_REQ, access_id:8'd40, core_id:4'h3,
                    addr:64'h10, byte_en:8'h00, data:64'h0};
        @(negedge clk);
        mem_req.access_id = 8'd41;
        @(negedge clk);
        mem_req = '0;
        checks++;
        if (mem_rsp.vld !== 1'b1 || mem_rsp.access_id !== 8'd40) begin
            errors++; $display("FAIL inflight_pre: got vld=%b id=%h expected 1/28", mem_rsp.vld, mem_rsp.access_id);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (mem_rsp !== '0 || req_grant !== 1'b0) begin
            errors++; $display("FAIL async_reset: got rsp=%h grant=%b expected 0/0", mem_rsp, req_grant);
        end
        rst_bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_rsp !== '0 || init_done !== 1'b0) rst_bad++;
        end
        checks++;
        if (rst_bad != 0) begin errors++; $display("FAIL during_reset: got %0d bad cycles expected 0", rst_bad); end
        release_and_count(1'b1, n, stale);
        checks++;
        if (n != MEM_DEPTH) begin errors++; $display("FAIL reinit_cycles: got %0d expected %0d", n, MEM_DEPTH); end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL stale_rsp: got %0d pulses expected 0", stale); end
        xact(READ_REQ, 8'd42, 64'h10, 8'h00, 64'h0, r);
        checks++;
        if (r.vld !== 1'b1 || r.access_id !== 8'd42 || r.data !== 64'h0) begin
            errors++; $display("FAIL reinit_clear: got vld=%b id=%h data=%h expected 1/2a/0", r.vld, r.access_id, r.data);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_partial();
        test_bounds();
        test_back_to_back();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
